glb_tile_sequencer: RTL and testbench

Walks one layer's work as a sequence of GLB tile descriptors, using the `tile_n` budget produced by the tile-size calculator. Each descriptor names one pixel chunk and one input/output channel tile. Descriptors go out over a valid/ready handshake to the GLB DMA/PE-array controller. The block sits between the layer-config registers and the tile-level controller, one instance per accelerator.

---
 rtl/tile_pkg.sv | 32 +++
 rtl/glb_tile_sequencer.sv | 167 ++++++++++++++++
 tb/tb_glb_tile_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_pkg.sv
// Shared definitions for the GLB tile sequencer: layer-type codes, FSM states
// and the tile descriptor record.
package tile_pkg;

  localparam int TP_PIX_W = 16;
  localparam int TP_CH_W  = 7;

  // Layer-type encodings
  localparam logic [1:0] LT_PW  = 2'd0;
  localparam logic [1:0] LT_DW  = 2'd1;
  localparam logic [1:0] LT_STD = 2'd2;
  localparam logic [1:0] LT_LIN = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [TP_PIX_W-1:0] pix_base;
    logic [TP_PIX_W-1:0] pix_cnt;
    logic [TP_CH_W-1:0]  d_base;
    logic [TP_CH_W-1:0]  d_cnt;
    logic [TP_CH_W-1:0]  k_base;
    logic [TP_CH_W-1:0]  k_cnt;
    logic                first_d;
    logic                last_d;
  } desc_t;

endpackage

// File: rtl/glb_tile_sequencer.sv
// GLB tile sequencer: walks k-tile / pixel-chunk / d-tile loops for one layer
// and hands out one descriptor per accepted handshake.
// Optional macro TILE_SEQ_PERF_EN adds the stall_cycles performance counter.
module glb_tile_sequencer
  import tile_pkg::*;
#(
  parameter int PIX_W = TP_PIX_W,
  parameter int CH_W  = TP_CH_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       layer_type,
  input  logic [CH_W-1:0]  in_C,
  input  logic [CH_W-1:0]  out_C,
  input  logic [CH_W-1:0]  tile_D,
  input  logic [CH_W-1:0]  tile_K,
  input  logic [PIX_W-1:0] total_pix,
  input  logic [31:0]      tile_n,
  output logic             desc_valid,
  input  logic             desc_ready,
  output logic [PIX_W-1:0] pix_base,
  output logic [PIX_W-1:0] pix_cnt,
  output logic [CH_W-1:0]  d_base,
  output logic [CH_W-1:0]  d_cnt,
  output logic [CH_W-1:0]  k_base,
  output logic [CH_W-1:0]  k_cnt,
  output logic             first_d,
  output logic             last_d,
  output logic             busy,
  output logic             done,
`ifdef TILE_SEQ_PERF_EN
  output logic [31:0]      stall_cycles,
`endif
  output logic             err
);

  state_t           r_state;
  logic [1:0]       r_lt;
  logic [CH_W-1:0]  r_in_c, r_out_c, r_tile_d, r_tile_k;
  logic [PIX_W-1:0] r_total, r_step;
  logic [31:0]      r_tile_n;
  logic [PIX_W-1:0] r_pix;
  logic [CH_W-1:0]  r_d, r_k;

  logic             w_dw, w_illegal, w_fire, w_emit;
  logic [PIX_W-1:0] w_step, w_pix_rem, w_pix_cnt;
  logic [CH_W-1:0]  w_d_rem, w_d_cnt, w_k_rem, w_k_cnt;
  logic [PIX_W:0]   w_pix_sum;
  logic [CH_W:0]    w_d_sum, w_k_sum;
  logic             w_d_wrap, w_pix_wrap, w_k_wrap;
  desc_t            w_desc;

  // Remainder-tile sizes and loop-advance sums; widened sums never wrap
  always_comb begin
    w_dw       = (r_lt == LT_DW);
    w_emit     = (r_state == ST_EMIT);
    w_fire     = w_emit && desc_ready;
    w_illegal  = (r_tile_n == 32'd0) || (r_total == '0) || (r_tile_d == '0) ||
                 (r_tile_k == '0) || (r_in_c == '0) || (r_out_c == '0);
    w_step     = (r_tile_n < {{(32-PIX_W){1'b0}}, r_total}) ? r_tile_n[PIX_W-1:0] : r_total;
    w_pix_rem  = r_total - r_pix;
    w_pix_cnt  = (r_step < w_pix_rem) ? r_step : w_pix_rem;
    w_d_rem    = r_in_c - r_d;
    w_d_cnt    = (r_tile_d < w_d_rem) ? r_tile_d : w_d_rem;
    w_k_rem    = r_out_c - r_k;
    w_k_cnt    = (r_tile_k < w_k_rem) ? r_tile_k : w_k_rem;
    w_pix_sum  = {1'b0, r_pix} + {1'b0, w_pix_cnt};
    w_d_sum    = {1'b0, r_d} + {1'b0, w_d_cnt};
    w_k_sum    = {1'b0, r_k} + {1'b0, w_k_cnt};
    w_d_wrap   = w_dw || (w_d_sum >= {1'b0, r_in_c});
    w_pix_wrap = (w_pix_sum >= {1'b0, r_total});
    w_k_wrap   = (w_k_sum >= {1'b0, r_out_c});
    // DW collapses the d loop onto the current k tile
    w_desc.pix_base = r_pix;
    w_desc.pix_cnt  = w_pix_cnt;
    w_desc.d_base   = w_dw ? r_k : r_d;
    w_desc.d_cnt    = w_dw ? w_k_cnt : w_d_cnt;
    w_desc.k_base   = r_k;
    w_desc.k_cnt    = w_k_cnt;
    w_desc.first_d  = w_dw || (r_d == '0);
    w_desc.last_d   = w_d_wrap;
  end

  // Sequencer FSM, config capture and loop counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_lt     <= '0;
      r_in_c   <= '0;
      r_out_c  <= '0;
      r_tile_d <= '0;
      r_tile_k <= '0;
      r_total  <= '0;
      r_tile_n <= '0;
      r_step   <= '0;
      r_pix    <= '0;
      r_d      <= '0;
      r_k      <= '0;
    end else if (flush) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          r_lt     <= layer_type;
          r_in_c   <= in_C;
          r_out_c  <= out_C;
          r_tile_d <= tile_D;
          r_tile_k <= tile_K;
          r_total  <= total_pix;
          r_tile_n <= tile_n;
          r_state  <= ST_LOAD;
        end
        ST_LOAD: begin
          if (w_illegal) r_state <= ST_IDLE;
          else begin
            r_step  <= w_step;
            r_pix   <= '0;
            r_d     <= '0;
            r_k     <= '0;
            r_state <= ST_EMIT;
          end
        end
        ST_EMIT: if (w_fire) begin
          if (!w_d_wrap) r_d <= w_d_sum[CH_W-1:0];
          else begin
            r_d <= '0;
            if (!w_pix_wrap) r_pix <= w_pix_sum[PIX_W-1:0];
            else begin
              r_pix <= '0;
              if (!w_k_wrap) r_k <= w_k_sum[CH_W-1:0];
              else r_state <= ST_DONE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef TILE_SEQ_PERF_EN
  logic [31:0] r_stall;
  // Counts cycles a valid descriptor waits on the consumer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stall <= '0;
    else if ((r_state == ST_IDLE) && start && !flush) r_stall <= '0;
    else if (w_emit && !desc_ready) r_stall <= r_stall + 32'd1;
  end
  assign stall_cycles = r_stall;
`endif

  // Descriptor fields read as zero outside EMIT
  assign desc_valid = w_emit;
  assign pix_base   = w_emit ? w_desc.pix_base : '0;
  assign pix_cnt    = w_emit ? w_desc.pix_cnt  : '0;
  assign d_base     = w_emit ? w_desc.d_base   : '0;
  assign d_cnt      = w_emit ? w_desc.d_cnt    : '0;
  assign k_base     = w_emit ? w_desc.k_base   : '0;
  assign k_cnt      = w_emit ? w_desc.k_cnt    : '0;
  assign first_d    = w_emit && w_desc.first_d;
  assign last_d     = w_emit && w_desc.last_d;
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign err        = (r_state == ST_LOAD) && w_illegal;

endmodule

// File: tb/tb_glb_tile_sequencer.sv
// Self-checking bench for glb_tile_sequencer: table of layer configs, random
// layers with random backpressure, plus flush / reset / illegal sequences.
module tb_glb_tile_sequencer;
  import tile_pkg::*;

  logic        clk = 0, rst_n = 0, start = 0, flush = 0, desc_ready = 0;
  logic [1:0]  layer_type = 0;
  logic [6:0]  in_C = 0, out_C = 0, tile_D = 0, tile_K = 0;
  logic [15:0] total_pix = 0;
  logic [31:0] tile_n = 0;
  logic        desc_valid, first_d, last_d, busy, done, err;
  logic [15:0] pix_base, pix_cnt;
  logic [6:0]  d_base, d_cnt, k_base, k_cnt;
`ifdef TILE_SEQ_PERF_EN
  logic [31:0] stall_cycles;
`endif

  glb_tile_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .layer_type(layer_type), .in_C(in_C), .out_C(out_C),
    .tile_D(tile_D), .tile_K(tile_K), .total_pix(total_pix), .tile_n(tile_n),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .pix_base(pix_base), .pix_cnt(pix_cnt), .d_base(d_base), .d_cnt(d_cnt),
    .k_base(k_base), .k_cnt(k_cnt), .first_d(first_d), .last_d(last_d),
    .busy(busy), .done(done),
`ifdef TILE_SEQ_PERF_EN
    .stall_cycles(stall_cycles),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  lt;
    int          in_c, out_c, td, tk, tp;
    logic [31:0] tn;
  } cfg_t;

  typedef struct {
    cfg_t c;
    int   exp_n;
  } vec_t;

  int    nchk = 0, nerr = 0;
  desc_t exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int imin(input longint a, input longint b);
    return int'((a < b) ? a : b);
  endfunction

  function automatic bit cfg_illegal(input cfg_t c);
    return (c.tn == 0) || (c.tp == 0) || (c.td == 0) || (c.tk == 0) ||
           (c.in_c == 0) || (c.out_c == 0);
  endfunction

  // Reference: enumerate the loop nest directly with integer arithmetic
  function automatic void build(input cfg_t c);
    int step;
    desc_t e;
    exp_q.delete();
    if (cfg_illegal(c)) return;
    step = imin(longint'(c.tn), longint'(c.tp));
    for (int k = 0; k < c.out_c; k += c.tk) begin
      int kc = imin(c.tk, c.out_c - k);
      for (int p = 0; p < c.tp; p += step) begin
        int pc = imin(step, c.tp - p);
        if (c.lt == LT_DW) begin
          e = '{16'(p), 16'(pc), 7'(k), 7'(kc), 7'(k), 7'(kc), 1'b1, 1'b1};
          exp_q.push_back(e);
        end else begin
          for (int d = 0; d < c.in_c; d += c.td) begin
            int dc = imin(c.td, c.in_c - d);
            e = '{16'(p), 16'(pc), 7'(d), 7'(dc), 7'(k), 7'(kc), d == 0, (d + dc) == c.in_c};
            exp_q.push_back(e);
          end
        end
      end
    end
  endfunction

  task automatic drive_cfg(input cfg_t c);
    layer_type = c.lt; in_C = 7'(c.in_c); out_C = 7'(c.out_c);
    tile_D = 7'(c.td); tile_K = 7'(c.tk); total_pix = 16'(c.tp); tile_n = c.tn;
  endtask

  task automatic scramble_cfg();
    layer_type = 2'($urandom); in_C = 7'($urandom); out_C = 7'($urandom);
    tile_D = 7'($urandom); tile_K = 7'($urandom); total_pix = 16'($urandom); tile_n = $urandom;
  endtask

  function automatic desc_t cur_desc();
    desc_t d;
    d = '{pix_base, pix_cnt, d_base, d_cnt, k_base, k_cnt, first_d, last_d};
    return d;
  endfunction

  // Runs one layer from start to done (or err), checking every valid cycle
  task automatic run_layer(input cfg_t c, input int pct, input int hold_idx, output int fired);
    int idx = 0, cyc = 0, hcnt = 0, stalls = 0;
    bit rdy;
    build(c);
    drive_cfg(c);
    start = 1;
    @(negedge clk);
    start = 0;
    scramble_cfg();
    desc_ready = 1'($urandom);
    chk("load_busy", busy, 1);
    chk("load_valid", desc_valid, 0);
    if (cfg_illegal(c)) begin
      chk("err_pulse", err, 1);
      @(negedge clk);
      chk("err_len", err, 0);
      chk("err_busy", busy, 0);
      chk("err_valid", desc_valid, 0);
      chk("err_done", done, 0);
      fired = 0;
      desc_ready = 0;
      return;
    end
    chk("load_err", err, 0);
    @(negedge clk);
    while (!done && cyc < 4000) begin
      if (!desc_valid) begin
        chk("valid_gap", 0, 1);
        break;
      end
      if (idx < exp_q.size()) chk($sformatf("desc%0d", idx), cur_desc(), exp_q[idx]);
      else chk("extra_desc", 1, 0);
      if (idx == hold_idx && hcnt < 3) begin rdy = 0; hcnt++; end
      else rdy = ($urandom_range(99) < pct);
      desc_ready = rdy;
      if (rdy) idx++;
      else stalls++;
      @(negedge clk);
      cyc++;
    end
    desc_ready = 0;
    if (cyc >= 4000) chk("timeout", 0, 1);
    chk("done_pulse", done, 1);
    chk("desc_count", idx, exp_q.size());
    chk("valid_at_done", desc_valid, 0);
    chk("busy_at_done", busy, 1);
`ifdef TILE_SEQ_PERF_EN
    chk("stall_cycles", stall_cycles, stalls);
`endif
    @(negedge clk);
    chk("done_len", done, 0);
    chk("busy_after", busy, 0);
    fired = idx;
  endtask

  vec_t vecs[12];
  int   fired;
  cfg_t rc;

  initial begin
    vecs[0]  = '{'{LT_PW,  8,   8,   8,  8,  10,    32'd4},          3};
    vecs[1]  = '{'{LT_STD, 20,  10,  8,  8,  4,     32'd100},        6};
    vecs[2]  = '{'{LT_DW,  12,  12,  4,  8,  6,     32'd6},          2};
    vecs[3]  = '{'{LT_LIN, 3,   3,   3,  3,  5,     32'hFFFF_FFFF},  1};
    vecs[4]  = '{'{LT_PW,  127, 127, 64, 100, 65535, 32'd40000},     8};
    vecs[5]  = '{'{LT_PW,  1,   1,   5,  5,  3,     32'd1},          3};
    vecs[6]  = '{'{LT_PW,  8,   8,   8,  8,  10,    32'd0},          0};
    vecs[7]  = '{'{LT_STD, 8,   8,   8,  8,  0,     32'd4},          0};
    vecs[8]  = '{'{LT_STD, 8,   8,   0,  8,  10,    32'd4},          0};
    vecs[9]  = '{'{LT_LIN, 0,   8,   8,  8,  10,    32'd4},          0};
    vecs[10] = '{'{LT_DW,  8,   0,   8,  8,  10,    32'd4},          0};
    vecs[11] = '{'{LT_PW,  8,   8,   8,  0,  10,    32'd4},          0};

    // Reset state
    #1;
    chk("rst_valid", desc_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_fields", {pix_base, pix_cnt, d_base, d_cnt, k_base, k_cnt, first_d, last_d}, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Directed table, full-rate ready
    for (int i = 0; i < 12; i++) begin
      run_layer(vecs[i].c, 100, -1, fired);
      chk($sformatf("vec%0d_n", i), fired, vecs[i].exp_n);
    end

    // Backpressure on descriptor 2
    run_layer(vecs[0].c, 100, 1, fired);
    chk("bp_n", fired, 3);

    // Flush together with the first fire
    drive_cfg(vecs[0].c);
    start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("fl_valid_before", desc_valid, 1);
    desc_ready = 1;
    flush = 1;
    @(negedge clk);
    flush = 0;
    desc_ready = 0;
    chk("fl_valid", desc_valid, 0);
    chk("fl_busy", busy, 0);
    chk("fl_done", done, 0);
    @(negedge clk);
    chk("fl_done2", done, 0);
    run_layer(vecs[0].c, 100, -1, fired);
    chk("fl_restart_n", fired, 3);

    // Reset mid-layer
    drive_cfg(vecs[1].c);
    start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    desc_ready = 1;
    #2 rst_n = 0;
    #1;
    chk("mr_valid", desc_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_fields", {pix_base, d_base, k_base, first_d}, 0);
    @(negedge clk);
    desc_ready = 0;
    rst_n = 1;
    @(negedge clk);
    chk("mr_done", done, 0);
    chk("mr_busy2", busy, 0);

    // Random layers with random backpressure
    for (int i = 0; i < 15; i++) begin
      rc.lt    = 2'($urandom_range(3));
      rc.in_c  = $urandom_range(30, 1);
      rc.td    = $urandom_range(30, 4);
      rc.out_c = $urandom_range(30, 1);
      rc.tk    = $urandom_range(30, 4);
      rc.tp    = $urandom_range(40, 1);
      rc.tn    = ($urandom_range(4) == 0) ? 32'h8000_0000 + $urandom_range(1000) : $urandom_range(60, 5);
      run_layer(rc, $urandom_range(100, 40), int'($urandom_range(5)) - 1, fired);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
